// File: rtl/seq_add32.sv
// Multi-cycle adder: A + B + Cin computed one Slice-bit chunk per clock, LSB chunk first.
// Optional SEQ_ADD_OVF_FLAG_EN adds a registered two's-complement overflow output (ovf).
module seq_add32 #(
  parameter int Width = 32,
  parameter int Slice = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic             Cin,
  output logic [Width-1:0] out,
  output logic             Cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SEQ_ADD_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE and out_valid only in DONE, so neither side is pre-accepted.

  localparam int N = Width / Slice;
  localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [Width-1:0]    a_q, a_d;
  logic [Width-1:0]    b_q, b_d;
  logic [Width-1:0]    out_q, out_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic [STEP_W-1:0]   step_q, step_d;

  logic [31:0]         chunk_lsb;
  logic [Slice-1:0]    a_chunk;
  logic [Slice-1:0]    b_chunk;
  logic [Slice:0]      chunk_sum;

`ifdef SEQ_ADD_OVF_FLAG_EN
  logic                ovf_q, ovf_d;
  logic                carry_into_msb;
`endif

  always_comb begin
    chunk_lsb = 32'(step_q) * 32'(Slice);
    a_chunk   = a_q[chunk_lsb +: Slice];
    b_chunk   = b_q[chunk_lsb +: Slice];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{Slice{1'b0}}, carry_q};
  end

`ifdef SEQ_ADD_OVF_FLAG_EN
  // Carry into the MSB is recovered from the MSB sum bit of the final chunk.
  assign carry_into_msb = a_chunk[Slice-1] ^ b_chunk[Slice-1] ^ chunk_sum[Slice-1];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    step_d  = step_q;
`ifdef SEQ_ADD_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          step_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        out_d[chunk_lsb +: Slice] = chunk_sum[Slice-1:0];
        carry_d = chunk_sum[Slice];
        step_d  = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          cout_d  = chunk_sum[Slice];
`ifdef SEQ_ADD_OVF_FLAG_EN
          ovf_d   = carry_into_msb ^ chunk_sum[Slice];
`endif
          step_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      step_q  <= '0;
`ifdef SEQ_ADD_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      step_q  <= step_d;
`ifdef SEQ_ADD_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign Cout      = cout_q;
`ifdef SEQ_ADD_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_add32.sv
// Bench for seq_add32: transaction-level model checked every cycle plus directed literal vectors.
// Build with SEQ_ADD_OVF_FLAG_EN defined to also check the ovf output.
module tb_seq_add32;
  localparam int W = 32;
  localparam int S = 8;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum_out;
  logic         cout;
  logic         out_valid;
  logic         out_ready;
`ifdef SEQ_ADD_OVF_FLAG_EN
  logic         ovf;
`endif

  seq_add32 #(.Width(W), .Slice(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .out       (sum_out),
    .Cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SEQ_ADD_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction model ----------------
  // A transaction is pending from its accept edge until its retire edge; the result
  // becomes visible N edges after acceptance. Results are plain 33-bit sums.
  logic [W:0] exp_q[$];
  logic       exp_ovf_q[$];
  bit         armed     = 1'b0;
  bit         m_pending = 1'b0;
  bit         m_done    = 1'b0;
  int         m_cnt     = 0;
  logic [W:0] m_hold    = '0;
  logic       m_hold_ovf = 1'b0;
  int         acc_count = 0;
  int         ret_count = 0;
  int         rise_q[$];
  logic       prev_valid = 1'b0;

  function automatic logic ovf_of(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      armed      = 1'b1;
      m_pending  = 1'b0;
      m_done     = 1'b0;
      m_cnt      = 0;
      m_hold     = '0;
      m_hold_ovf = 1'b0;
      exp_q.delete();
      exp_ovf_q.delete();
    end else if (!m_pending) begin
      if (in_valid) begin
        exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        exp_ovf_q.push_back(ovf_of(a, b, cin));
        m_pending = 1'b1;
        m_done    = 1'b0;
        m_cnt     = 0;
        acc_count++;
      end
    end else if (!m_done) begin
      m_cnt++;
      if (m_cnt == N) m_done = 1'b1;
    end else if (out_ready) begin
      m_hold     = exp_q.pop_front();
      m_hold_ovf = exp_ovf_q.pop_front();
      m_pending  = 1'b0;
      m_done     = 1'b0;
      ret_count++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (armed) begin
      check("in_ready", 64'(in_ready), 64'(!m_pending));
      check("out_valid", 64'(out_valid), 64'(m_done));
      if (m_done && exp_q.size() > 0) begin
        check("done_sum", 64'({cout, sum_out}), 64'(exp_q[0]));
`ifdef SEQ_ADD_OVF_FLAG_EN
        check("done_ovf", 64'(ovf), 64'(exp_ovf_q[0]));
`endif
      end else if (!m_pending) begin
        check("idle_hold", 64'({cout, sum_out}), 64'(m_hold));
`ifdef SEQ_ADD_OVF_FLAG_EN
        check("idle_ovf", 64'(ovf), 64'(m_hold_ovf));
`endif
      end
      if (out_valid && !prev_valid) rise_q.push_back(cyc);
      prev_valid = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with the DUT idle; offers one operand set and checks the literal result.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic [W-1:0] e_out, input logic e_cout,
                        input logic e_ovf);
    int n;
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(N));
    check({tag, "_out"}, 64'(sum_out), 64'(e_out));
    check({tag, "_cout"}, 64'(cout), 64'(e_cout));
`ifdef SEQ_ADD_OVF_FLAG_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
`else
    if (e_ovf === 1'bx) $display("note: unexpected X flag");
`endif
    @(negedge clk);
    check({tag, "_idle_again"}, 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  task automatic wait_retired(input int target, input string tag);
    int n;
    n = 0;
    while (ret_count < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_retired"}, 64'(ret_count), 64'(target));
  endtask

  // ---------------- directed stimulus ----------------
  logic [W-1:0] b2b_a[3];
  logic [W-1:0] b2b_b[3];
  logic         b2b_c[3];

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", 64'(sum_out), 64'h0);
    check("rst_cout", 64'(cout), 64'h0);
    check("rst_flags", 64'({in_ready, out_valid}), 64'(2'b10));
    rst = 1'b0;
    @(negedge clk);

    run_op("basic", 32'h0000_1234, 32'h0000_4321, 1'b0, 32'h0000_5555, 1'b0, 1'b0);
    run_op("carry_all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Backpressure: result held 5 cycles while new operands wait on the input.
    a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b1;
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("bp_latency", 64'(n), 64'(N));
    end
    repeat (5) begin
      check("bp_out", 64'({cout, sum_out}), 64'({1'b1, 32'h0000_0000}));
`ifdef SEQ_ADD_OVF_FLAG_EN
      check("bp_ovf", 64'(ovf), 64'h1);
`endif
      check("bp_no_accept", 64'(in_ready), 64'h0);
      @(negedge clk);
    end
    check("bp_acc_count", 64'(acc_count), 64'(5));
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_retired_idle", 64'({in_ready, out_valid}), 64'(2'b10));
    @(negedge clk);
    check("bp_second_accept", 64'(acc_count), 64'(6));
    in_valid = 1'b0;
    wait_retired(6, "bp2");
    check("bp2_out", 64'({cout, sum_out}), 64'({1'b0, 32'h3333_3334}));

    // Reset during the second BUSY cycle aborts the operation.
    @(negedge clk);
    a = 32'h0101_0101; b = 32'h0202_0202; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out", 64'(sum_out), 64'h0);
    check("abort_flags", 64'({in_ready, out_valid}), 64'(2'b10));
    run_op("after_abort", 32'h0101_0101, 32'h0202_0202, 1'b0, 32'h0303_0303, 1'b0, 1'b0);

    // Back-to-back: in_valid and out_ready held high across three operations.
    b2b_a[0] = 32'h0000_0001; b2b_b[0] = 32'h0000_0002; b2b_c[0] = 1'b0;
    b2b_a[1] = 32'hAAAA_AAAA; b2b_b[1] = 32'h5555_5555; b2b_c[1] = 1'b1;
    b2b_a[2] = 32'h1234_5678; b2b_b[2] = 32'h9ABC_DEF0; b2b_c[2] = 1'b0;
    rise_q.delete();
    begin
      int base;
      int n;
      base = acc_count;
      ret_count = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        a = b2b_a[i]; b = b2b_b[i]; cin = b2b_c[i]; in_valid = 1'b1;
        n = 0;
        while (acc_count < base + i + 1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("b2b_accept", 64'(acc_count), 64'(base + i + 1));
        if (i == 2) in_valid = 1'b0;
        else begin a = $urandom; b = $urandom; end
      end
      in_valid = 1'b0;
      wait_retired(3, "b2b");
      check("b2b_last_out", 64'({cout, sum_out}), 64'({1'b0, 32'hACF1_3568}));
      check("b2b_rises", 64'(rise_q.size()), 64'(3));
      if (rise_q.size() == 3) begin
        check("b2b_gap1", 64'(rise_q[1] - rise_q[0]), 64'(N + 2));
        check("b2b_gap2", 64'(rise_q[2] - rise_q[1]), 64'(N + 2));
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
